// File: rtl/reg_fifo.sv
// Register-based synchronous FIFO with push/pop handshake, occupancy count and sticky error flags.
// Optional feature: define REG_FIFO_BYPASS_EN to forward wr_data straight to rd_data on push+pop while empty.
module reg_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             underflow
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wp_q, wp_d;
  logic [AW-1:0]    rp_q, rp_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic empty_w, full_w, push_ok, pop_ok, bypass;

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == (AW+1)'(DEPTH));

`ifdef REG_FIFO_BYPASS_EN
  assign bypass = empty_w && wr_en && rd_en;
`else
  assign bypass = 1'b0;
`endif

  // A pop frees a slot on the same edge, so a push into a full FIFO is legal alongside it.
  assign pop_ok  = rd_en && !empty_w;
  assign push_ok = wr_en && (!full_w || pop_ok) && !bypass;

  always_comb begin
    wp_d       = wp_q;
    rp_d       = rp_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    ovf_d      = ovf_q | (wr_en && !push_ok && !bypass);
    unf_d      = unf_q | (rd_en && !pop_ok && !bypass);

    if (push_ok) wp_d = wp_q + AW'(1);
    if (pop_ok) begin
      rp_d       = rp_q + AW'(1);
      rd_data_d  = mem_q[rp_q];
      rd_valid_d = 1'b1;
    end else if (bypass) begin
      rd_data_d  = wr_data;
      rd_valid_d = 1'b1;
    end

    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q       <= '0;
      rp_q       <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  // Storage is never reset; only the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem_q[wp_q] <= wr_data;
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign full      = full_w;
  assign empty     = empty_w;
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_reg_fifo.sv
// Randomized bench for reg_fifo, compared cycle by cycle against a queue-based reference model.
module tb_reg_fifo;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             wr_en = 1'b0;
  logic [WIDTH-1:0] wr_data = '0;
  logic             rd_en = 1'b0;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid, full, empty, overflow, underflow;
  logic [AW:0]      count;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] m_rdd = '0;
  logic             m_rdv = 1'b0;
  logic             m_ovf = 1'b0;
  logic             m_unf = 1'b0;

  always #5 clk = ~clk;

  reg_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: the FIFO is a queue; one call per rising edge using pre-edge state.
  task automatic model_step(input logic r, input logic w, input logic [WIDTH-1:0] d, input logic p);
    bit is_empty, is_full, byp, pop_ok, push_ok;
    if (r) begin
      q.delete();
      m_rdd = '0; m_rdv = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
      return;
    end
    is_empty = (q.size() == 0);
    is_full  = (q.size() == DEPTH);
`ifdef REG_FIFO_BYPASS_EN
    byp = is_empty && w && p;
`else
    byp = 1'b0;
`endif
    pop_ok  = p && !is_empty;
    push_ok = w && (!is_full || pop_ok) && !byp;
    if (pop_ok) begin
      m_rdd = q.pop_front();
      m_rdv = 1'b1;
    end else if (byp) begin
      m_rdd = d;
      m_rdv = 1'b1;
    end else begin
      m_rdv = 1'b0;
    end
    if (push_ok) q.push_back(d);
    if (w && !push_ok && !byp) m_ovf = 1'b1;
    if (p && !pop_ok && !byp) m_unf = 1'b1;
  endtask

  task automatic compare_all();
    chk("count", 32'(count), 32'(q.size()));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    chk("rd_valid", 32'(rd_valid), 32'(m_rdv));
    chk("rd_data", 32'(rd_data), 32'(m_rdd));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
  endtask

  task automatic cyc(input logic r, input logic w, input logic [WIDTH-1:0] d, input logic p);
    rst = r; wr_en = w; wr_data = d; rd_en = p;
    @(posedge clk);
    model_step(r, w, d, p);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    logic [WIDTH-1:0] seq [4];
    seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33; seq[3] = 8'h44;
    @(negedge clk);

    // Reset then idle
    cyc(1, 0, 8'h00, 0);
    cyc(0, 0, 8'h00, 0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_rd_data", 32'(rd_data), 32'h0);

    // Fill, overflow, drain
    for (int i = 0; i < 4; i++) cyc(0, 1, seq[i], 0);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd4);
    cyc(0, 1, 8'h55, 0);
    chk("ovf_set", 32'(overflow), 32'd1);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 8'h00, 1);
      chk("drain_data", 32'(rd_data), 32'(seq[i]));
      chk("drain_valid", 32'(rd_valid), 32'd1);
    end
    chk("drain_empty", 32'(empty), 32'd1);

    // Push+pop while full
    for (int i = 0; i < 4; i++) cyc(0, 1, seq[i], 0);
    cyc(0, 1, 8'hA0, 1);
    chk("fullpp_data", 32'(rd_data), 32'h11);
    chk("fullpp_count", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) cyc(0, 0, 8'h00, 1);
    chk("fullpp_last", 32'(rd_data), 32'hA0);

    // Pop on empty
    cyc(0, 0, 8'h00, 1);
    chk("unf_set", 32'(underflow), 32'd1);
    chk("unf_rdv", 32'(rd_valid), 32'd0);
    chk("unf_rdd_hold", 32'(rd_data), 32'hA0);
    cyc(0, 0, 8'h00, 0);
    chk("unf_sticky", 32'(underflow), 32'd1);

    // Push+pop on empty
    cyc(1, 0, 8'h00, 0);
    cyc(0, 1, 8'h5A, 1);
`ifdef REG_FIFO_BYPASS_EN
    chk("byp_data", 32'(rd_data), 32'h5A);
    chk("byp_valid", 32'(rd_valid), 32'd1);
    chk("byp_count", 32'(count), 32'd0);
    chk("byp_unf", 32'(underflow), 32'd0);
`else
    chk("nobyp_count", 32'(count), 32'd1);
    chk("nobyp_unf", 32'(underflow), 32'd1);
    cyc(0, 0, 8'h00, 1);
    chk("nobyp_data", 32'(rd_data), 32'h5A);
`endif

    // Reset mid-operation with push and pop requested
    cyc(1, 0, 8'h00, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, seq[i], 0);
    cyc(1, 1, 8'hEE, 1);
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_rdv", 32'(rd_valid), 32'd0);

    // Ten pushes/pops across pointer wrap-around
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1, 8'(8'hC0 + i), 0);
      cyc(0, 0, 8'h00, 1);
      chk("wrap_data", 32'(rd_data), 32'(8'hC0 + i));
    end

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0),
          8'($urandom), ($urandom_range(0, 2) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
